// File: rtl/shift_cnt_ctrl.sv
// Commanded ring/Johnson shift-register counter: runs a bounded or free-running
// sequence on start, with pause/stop control and done/wrap pulses.
module shift_cnt_ctrl #(
  parameter int N     = 4,
  parameter int STEPW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [N-1:0]     seed,
  input  logic [STEPW-1:0] num_steps,
  output logic [N-1:0]     cnt_out,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  localparam int PW = $clog2(2 * N);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_r;
  logic [STEPW-1:0] remaining_r;
  logic [PW-1:0]    phase_r;
  logic             mode_r;

  logic [N-1:0]     load_s;
  logic [N-1:0]     shift_s;
  logic [PW-1:0]    phase_last_s;

  // Load value for a new run; an all-zero ring seed would never rotate anything visible.
  always_comb begin
    load_s = {N{1'b0}};
    if (mode == 1'b1) begin
      load_s = {N{1'b0}};
    end else if (seed == {N{1'b0}}) begin
      load_s = {{(N-1){1'b0}}, 1'b1};
    end else begin
      load_s = seed;
    end
  end

  // Next counter value and last phase of the period for the latched mode.
  always_comb begin
    shift_s      = {cnt_out[N-2:0], (mode_r ? ~cnt_out[N-1] : cnt_out[N-1])};
    phase_last_s = mode_r ? PW'(2 * N - 1) : PW'(N - 1);
  end

  // Sequencer: latches the command, steps the counter and raises the status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      cnt_out     <= {N{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      wrap        <= 1'b0;
      remaining_r <= {STEPW{1'b0}};
      phase_r     <= {PW{1'b0}};
      mode_r      <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            mode_r      <= mode;
            remaining_r <= num_steps;
            cnt_out     <= load_s;
            phase_r     <= {PW{1'b0}};
            state_r     <= RUN;
            busy        <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else if (!pause) begin
            cnt_out <= shift_s;
            if (phase_r == phase_last_s) begin
              phase_r <= {PW{1'b0}};
              wrap    <= 1'b1;
            end else begin
              phase_r <= phase_r + PW'(1);
            end
            // A zero remaining count while running means a free-run.
            if (remaining_r != {STEPW{1'b0}}) begin
              remaining_r <= remaining_r - STEPW'(1);
              if (remaining_r == STEPW'(1)) begin
                state_r <= IDLE;
                busy    <= 1'b0;
                done    <= 1'b1;
              end
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_cnt_ctrl.sv
// Self-checking bench for shift_cnt_ctrl: step-count model plus directed
// sequences with literal expectations.
module tb_shift_cnt_ctrl;

  localparam int N     = 4;
  localparam int STEPW = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic             stop;
  logic             pause;
  logic             mode;
  logic [N-1:0]     seed;
  logic [STEPW-1:0] num_steps;
  logic [N-1:0]     cnt_out;
  logic             busy;
  logic             done;
  logic             wrap;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  shift_cnt_ctrl #(.N(N), .STEPW(STEPW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .mode      (mode),
    .seed      (seed),
    .num_steps (num_steps),
    .cnt_out   (cnt_out),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Counter value after s shifts from the load value, from the sequence definitions.
  function automatic logic [N-1:0] seq_value(input logic [N-1:0] load, input logic md, input int s);
    int k;
    logic [2*N-1:0] dbl;
    if (md) begin
      k = s % (2 * N);
      if (k <= N) return N'((1 << k) - 1);
      else        return N'(((1 << N) - 1) & ~((1 << (k - N)) - 1));
    end else begin
      k   = s % N;
      dbl = {load, load} << k;
      return dbl[2*N-1:N];
    end
  endfunction

  // Model: a run is a load value plus a count of shifts taken so far.
  logic         m_run = 1'b0;
  logic         m_mode = 1'b0;
  logic [N-1:0] m_load = '0;
  logic [N-1:0] m_cnt = '0;
  logic         m_done = 1'b0;
  logic         m_wrap = 1'b0;
  int           m_steps = 0;
  int           m_limit = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run = 1'b0; m_mode = 1'b0; m_cnt = '0; m_done = 1'b0; m_wrap = 1'b0;
      m_steps = 0; m_limit = 0;
    end else begin
      m_done = 1'b0;
      m_wrap = 1'b0;
      if (!m_run) begin
        if (start) begin
          m_run   = 1'b1;
          m_mode  = mode;
          m_limit = int'(num_steps);
          m_load  = mode ? 4'b0000 : ((seed == 4'b0000) ? 4'b0001 : seed);
          m_steps = 0;
          m_cnt   = m_load;
        end
      end else if (stop) begin
        m_run = 1'b0;
      end else if (!pause) begin
        m_steps = m_steps + 1;
        m_cnt   = seq_value(m_load, m_mode, m_steps);
        if (m_steps % (m_mode ? 2 * N : N) == 0) m_wrap = 1'b1;
        if (m_limit != 0 && m_steps == m_limit) begin
          m_run  = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_cnt",  int'(cnt_out), int'(m_cnt));
      check("cmp_busy", int'(busy),    int'(m_run));
      check("cmp_done", int'(done),    int'(m_done));
      check("cmp_wrap", int'(wrap),    int'(m_wrap));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic launch(input logic md, input logic [N-1:0] sd, input logic [STEPW-1:0] ns);
    mode = md; seed = sd; num_steps = ns; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [N-1:0] ring_exp [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [N-1:0] john_exp [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                 4'b1110, 4'b1100, 4'b1000, 4'b0000};

  initial begin
    int busy_cycles;
    int wraps;
    int dones;
    int cyc;
    logic seen_done;

    start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 1'b0;
    seed = 4'b0000; num_steps = 8'd0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #20 rst = 1'b1;
    chk_en = 1'b1;

    // Reset state; stop in IDLE does nothing.
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("rst_cnt",  int'(cnt_out), 0);
    check("rst_busy", int'(busy),    0);

    // Ring, seed 0001, 5 steps.
    launch(1'b0, 4'b0001, 8'd5);
    check("ring_load", int'(cnt_out), 1);
    busy_cycles = int'(busy);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("ring_seq",  int'(cnt_out), int'(ring_exp[i]));
      check("ring_wrap", int'(wrap), (i == 3) ? 1 : 0);
      check("ring_done", int'(done), (i == 4) ? 1 : 0);
      busy_cycles += int'(busy);
    end
    check("ring_busy_len", busy_cycles, 5);
    tick();

    // Johnson, 8 steps: wrap and done together at the end.
    launch(1'b1, 4'b1010, 8'd8);
    check("john_load", int'(cnt_out), 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("john_seq", int'(cnt_out), int'(john_exp[i]));
    end
    check("john_wrap_end", int'(wrap), 1);
    check("john_done_end", int'(done), 1);
    tick();

    // Zero ring seed becomes 0001.
    launch(1'b0, 4'b0000, 8'd1);
    check("zseed_load", int'(cnt_out), 1);
    tick();
    check("zseed_shift", int'(cnt_out), 2);
    check("zseed_done",  int'(done), 1);

    // Multi-hot seed rotates unmodified.
    launch(1'b0, 4'b0101, 8'd2);
    tick();
    check("mh_1", int'(cnt_out), 10);
    tick();
    check("mh_2",    int'(cnt_out), 5);
    check("mh_done", int'(done), 1);
    tick();

    // Pause for 3 cycles after the 2nd shift: done 9 cycles after start.
    launch(1'b0, 4'b0001, 8'd6);
    seen_done = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 20 && !seen_done; c++) begin
      pause = (c >= 3 && c <= 5);
      tick();
      cyc = c;
      if (c >= 3 && c <= 5) begin
        check("pause_cnt",  int'(cnt_out), 4);
        check("pause_busy", int'(busy), 1);
      end
      seen_done = done;
    end
    pause = 1'b0;
    check("pause_done_seen", int'(seen_done), 1);
    check("pause_done_cyc",  cyc, 9);
    tick();

    // Stop after the 3rd shift.
    launch(1'b0, 4'b0001, 8'd6);
    tick(); tick(); tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_busy", int'(busy), 0);
    check("stop_cnt",  int'(cnt_out), 8);
    check("stop_done", int'(done), 0);
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      dones += int'(done);
    end
    check("stop_no_done", dones, 0);
    check("stop_hold",    int'(cnt_out), 8);

    // Johnson free-run, with start re-asserted mid-run.
    launch(1'b1, 4'b0000, 8'd0);
    wraps = 0;
    dones = 0;
    for (int i = 1; i <= 20; i++) begin
      start = (i >= 5 && i <= 7);
      mode  = 1'b0;
      seed  = 4'b0110;
      num_steps = 8'd3;
      tick();
      wraps += int'(wrap);
      dones += int'(done);
      if (i == 8 || i == 16) check("free_wrap_pos", int'(wrap), 1);
    end
    start = 1'b0;
    check("free_wraps", wraps, 2);
    check("free_dones", dones, 0);
    check("free_busy",  int'(busy), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("free_stop_busy", int'(busy), 0);

    // Asynchronous reset while wrap is high.
    launch(1'b1, 4'b0000, 8'd0);
    for (int i = 0; i < 8; i++) tick();
    check("pre_rst_wrap", int'(wrap), 1);
    #1 rst = 1'b0;
    #1;
    check("arst_cnt",  int'(cnt_out), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_wrap", int'(wrap), 0);
    check("arst_done", int'(done), 0);
    tick();
    #1 rst = 1'b1;
    tick();
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_cnt",  int'(cnt_out), 0);
    launch(1'b0, 4'b0010, 8'd1);
    check("restart_cnt",  int'(cnt_out), 2);
    check("restart_busy", int'(busy), 1);
    tick();
    check("restart_shift", int'(cnt_out), 4);
    check("restart_done",  int'(done), 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
